clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 8 +
 rtl/clk_div_chan.sv | 58 +++++
 rtl/clk_div_multi.sv | 47 ++++
 tb/tb_clk_div_multi.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and helpers for the multi-channel clock divider
package clk_div_pkg;
    localparam int DEF_W = 8;
    localparam int DEF_DIV_VAL = 10;
    function automatic int unsigned ceil_half(input int unsigned d);
        return (d + 1) / 2;
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with glitch-free divisor hand-over at period boundaries
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic         clk_in,
    input  logic         ar,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] wdiv,
    input  logic         resync,
    output logic         clk_out,
    output logic         tick,
    output logic         pend
);
    logic [W-1:0] phase, div, pdiv, div_s, div_n, phase_n;
    logic run, start, hi;
    // a period starts on first enabled edge, on resync, or when the last phase completes
    always_comb begin
        start = !run || resync || phase == div - W'(1);
        div_s = wr ? wdiv : (pend ? pdiv : div);
        div_n = start ? div_s : div;
        phase_n = start ? '0 : phase + W'(1);
        hi = phase_n < W'(ceil_half(32'(div_n)));
    end
    // phase/divisor state and registered outputs
    always_ff @(posedge clk_in) begin
        if (ar) begin
            phase <= '0;
            div <= W'(DEF_DIV);
            pdiv <= W'(DEF_DIV);
            pend <= 1'b0;
            run <= 1'b0;
            clk_out <= 1'b0;
            tick <= 1'b0;
        end else if (!en) begin
            phase <= '0;
            div <= div_s;
            pend <= 1'b0;
            run <= 1'b0;
            clk_out <= 1'b0;
            tick <= 1'b0;
        end else begin
            phase <= phase_n;
            div <= div_n;
            run <= 1'b1;
            clk_out <= hi;
            tick <= start;
            if (start) pend <= 1'b0;
            else if (wr) begin
                pdiv <= wdiv;
                pend <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent programmable clock dividers sharing one config port
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W = DEF_W,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic                              clk_in,
    input  logic                              ar,
    input  logic [NCH-1:0]                    ch_en,
    input  logic                              cfg_wr,
    input  logic [$clog2(NCH>1?NCH:2)-1:0]    cfg_ch,
    input  logic [W-1:0]                      cfg_div,
    input  logic                              resync,
    output logic [NCH-1:0]                    clk_out,
    output logic [NCH-1:0]                    tick,
    output logic [NCH-1:0]                    cfg_pend,
    output logic                              cfg_err
);
    logic div_ok, ch_ok;
    // write legality: divisor of at least 2 aimed at an existing channel
    always_comb begin
        div_ok = cfg_div >= W'(2);
        ch_ok = 32'(cfg_ch) < NCH;
    end
    // rejected writes raise a one-cycle error pulse
    always_ff @(posedge clk_in) begin
        cfg_err <= !ar && cfg_wr && !(div_ok && ch_ok);
    end
    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            clk_div_chan #(.W(W), .DEF_DIV(DEF_DIV)) u_chan (
                .clk_in(clk_in),
                .ar(ar),
                .en(ch_en[i]),
                .wr(cfg_wr && div_ok && 32'(cfg_ch) == i),
                .wdiv(cfg_div),
                .resync(resync),
                .clk_out(clk_out[i]),
                .tick(tick[i]),
                .pend(cfg_pend[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: randomized scoreboard bench with a time-based reference model
module tb_clk_div_multi;
    localparam int NCH = 5;
    localparam int W = 8;
    localparam int DEF_DIV = 10;
    localparam int CW = 3;
    logic clk_in = 0;
    logic ar = 1, cfg_wr = 0, resync = 0;
    logic [NCH-1:0] ch_en = '0;
    logic [CW-1:0] cfg_ch = '0;
    logic [W-1:0] cfg_div = '0;
    logic [NCH-1:0] clk_out, tick, cfg_pend;
    logic cfg_err;

    clk_div_multi #(.NCH(NCH), .W(W), .DEF_DIV(DEF_DIV)) dut (
        .clk_in(clk_in), .ar(ar), .ch_en(ch_en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .resync(resync), .clk_out(clk_out), .tick(tick),
        .cfg_pend(cfg_pend), .cfg_err(cfg_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [NCH-1:0] c;
        logic [NCH-1:0] t;
        logic [NCH-1:0] p;
        logic e;
    } exp_t;
    exp_t q[$];
    int errors = 0, checks = 0, n = 0;
    bit started = 0;
    int st[NCH], d[NCH], pd[NCH];
    bit pf[NCH], on[NCH];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, n, act, want);
        end
    endtask

    // Reference: each channel remembers when its period began and its divisor;
    // position in the period is elapsed cycles since that start.
    task automatic model();
        exp_t e;
        n++;
        for (int i = 0; i < NCH; i++) begin
            bit w;
            w = cfg_wr && cfg_div >= 2 && cfg_ch == i;
            if (ar) begin
                d[i] = DEF_DIV; pf[i] = 0; on[i] = 0; e.c[i] = 0; e.t[i] = 0;
            end else if (!ch_en[i]) begin
                if (w) d[i] = cfg_div; else if (pf[i]) d[i] = pd[i];
                pf[i] = 0; on[i] = 0; e.c[i] = 0; e.t[i] = 0;
            end else begin
                if (!on[i] || resync || n - st[i] == d[i]) begin
                    st[i] = n;
                    if (w) d[i] = cfg_div; else if (pf[i]) d[i] = pd[i];
                    pf[i] = 0;
                end else if (w) begin
                    pd[i] = cfg_div; pf[i] = 1;
                end
                on[i] = 1;
                e.c[i] = (n - st[i]) < (d[i] + 1) / 2;
                e.t[i] = n == st[i];
            end
            e.p[i] = pf[i];
        end
        e.e = !ar && cfg_wr && (cfg_div < 2 || cfg_ch >= NCH);
        q.push_back(e);
    endtask

    task automatic step(input logic a, input logic [NCH-1:0] en, input logic wr = 0,
                        input int ch = 0, input int dv = 0, input logic rs = 0);
        @(negedge clk_in);
        ar = a; ch_en = en; cfg_wr = wr; cfg_ch = CW'(ch); cfg_div = W'(dv); resync = rs;
        started = 1;
        model();
    endtask

    task automatic idle(input int k, input logic [NCH-1:0] en);
        for (int j = 0; j < k; j++) step(0, en);
    endtask

    // monitor: compare each registered output set against the scoreboard
    always @(posedge clk_in) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("clk_out", 32'(clk_out), 32'(e.c));
            cmp("tick", 32'(tick), 32'(e.t));
            cmp("cfg_pend", 32'(cfg_pend), 32'(e.p));
            cmp("cfg_err", 32'(cfg_err), 32'(e.e));
        end else if (started) cmp("scoreboard_underflow", 1, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", n);
        $fatal(1, "timeout");
    end

    initial begin
        int tk0, hi0;
        logic [NCH-1:0] en;
        repeat (3) step(1, '0);
        // default divisor on ch0: 3 ticks and 15 high cycles over 30 cycles
        tk0 = 0; hi0 = 0;
        step(0, 5'b00001);
        for (int j = 0; j < 30; j++) begin
            step(0, 5'b00001);
            tk0 += int'(tick[0]); hi0 += int'(clk_out[0]);
        end
        cmp("ticks_in_30", 32'(tk0), 3);
        cmp("high_in_30", 32'(hi0), 15);
        // mid-period writes on ch1, last one wins at the boundary
        step(0, 5'b00001);
        step(0, 5'b00011);
        step(0, 5'b00011);
        step(0, 5'b00011, 1, 1, 9);
        step(0, 5'b00011, 1, 1, 7);
        idle(25, 5'b00011);
        // rejected writes
        step(0, 5'b00011, 1, 0, 1);
        step(0, 5'b00011, 1, 5, 7);
        step(0, 5'b00011, 1, 2, 0);
        idle(5, 5'b00011);
        // resync, then resync with a same-cycle write
        step(0, 5'b00011, 0, 0, 0, 1);
        idle(6, 5'b00011);
        step(0, 5'b00011, 1, 1, 3, 1);
        idle(8, 5'b00011);
        // ch2 enable, drop mid-high, re-enable; write while disabled
        idle(2, 5'b00111);
        step(0, 5'b00011, 1, 2, 2);
        idle(3, 5'b00011);
        idle(8, 5'b00111);
        // max divisor then reset mid-period
        step(0, 5'b00001, 1, 0, 255);
        idle(300, 5'b00001);
        step(1, 5'b00001, 1, 0, 4, 1);
        idle(25, 5'b00001);
        // randomized traffic
        en = 5'b11111;
        for (int j = 0; j < 1500; j++) begin
            int r, dv;
            if ($urandom_range(0, 39) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            r = int'($urandom_range(0, 9));
            dv = r == 0 ? int'($urandom_range(0, 1)) : r == 1 ? 255 : int'($urandom_range(2, 16));
            step($urandom_range(0, 299) == 0, en, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 7)), dv, $urandom_range(0, 49) == 0);
        end
        step(0, en);
        @(posedge clk_in);
        #2;
        cmp("scoreboard_drain", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
